// File: rtl/bcd_stopwatch_ctrl_pkg.sv
// Shared types and constants for the BCD stopwatch controller.
package bcd_stopwatch_ctrl_pkg;

  localparam int         DIGIT_W = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_e;

endpackage

// File: rtl/bcd_stopwatch_ctrl_if.sv
// Command pulses in, BCD count and status out, between button logic and display driver.
interface bcd_stopwatch_ctrl_if #(
  parameter int DIGITS = 4
);
  import bcd_stopwatch_ctrl_pkg::*;

  logic                        start;
  logic                        stop;
  logic                        clear;
  logic                        lap;
  logic [DIGIT_W*DIGITS-1:0]   count;
  logic [DIGIT_W*DIGITS-1:0]   lap_count;
  logic                        running;
  logic                        ovf;

  modport master (
    output start, stop, clear, lap,
    input  count, lap_count, running, ovf
  );

  modport slave (
    input  start, stop, clear, lap,
    output count, lap_count, running, ovf
  );

endinterface

// File: rtl/bcd_stopwatch_ctrl_bcd_digit.sv
// One decimal digit 0-9; wraps and carries when incremented at 9.
module bcd_digit
  import bcd_stopwatch_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               inc,
  output logic [DIGIT_W-1:0] q,
  output logic               carry_out
);

  logic [DIGIT_W-1:0] q_q;
  logic [DIGIT_W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc) begin
      q_d = (q_q == BCD_MAX) ? '0 : q_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q         = q_q;
  assign carry_out = inc & (q_q == BCD_MAX);

endmodule

// File: rtl/bcd_stopwatch_ctrl.sv
// Start/stop/clear stopwatch: control FSM, tick prescaler, cascaded BCD digits,
// lap snapshot register and sticky wrap flag.
module bcd_stopwatch_ctrl #(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  bcd_stopwatch_ctrl_if.slave  bus
);
  import bcd_stopwatch_ctrl_pkg::*;

  localparam int            PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam int            CW        = DIGIT_W * DIGITS;

  state_e          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [CW-1:0]   lap_q, lap_d;
  logic            ovf_q, ovf_d;
  logic            running_q, running_d;
  logic [CW-1:0]   count_w;
  logic [DIGITS:0] carry;
  logic            tick;

  assign tick     = (state_q == RUN) && (presc_q == PRESC_MAX);
  assign carry[0] = tick;

  // Carry into digit k is high only when every lower digit sits at 9 on a tick.
  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clk       (clk),
      .rst       (rst),
      .clr       (bus.clear),
      .inc       (carry[g]),
      .q         (count_w[g*DIGIT_W +: DIGIT_W]),
      .carry_out (carry[g+1])
    );
  end

  // stop masks start on the same edge; clear overrides everything.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start && !bus.stop) state_d = RUN;
      RUN:     if (bus.stop)               state_d = PAUSE;
      PAUSE:   if (bus.start && !bus.stop) state_d = RUN;
      default: state_d = IDLE;
    endcase
    if (bus.clear) state_d = IDLE;

    presc_d = presc_q;
    if (state_q == RUN) presc_d = tick ? '0 : presc_q + PW'(1);
    if (bus.clear) presc_d = '0;

    ovf_d     = bus.clear ? 1'b0 : (ovf_q | carry[DIGITS]);
    lap_d     = bus.lap ? count_w : lap_q;
    running_d = (state_d == RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      lap_q     <= '0;
      ovf_q     <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      lap_q     <= lap_d;
      ovf_q     <= ovf_d;
      running_q <= running_d;
    end
  end

  assign bus.count     = count_w;
  assign bus.lap_count = lap_q;
  assign bus.running   = running_q;
  assign bus.ovf       = ovf_q;

endmodule
